// File: rtl/rep_sub_divider_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package rep_sub_divider_pkg;

  localparam int DEF_WIDTH = 16;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    CHECK  = 3'd2,
    SUB    = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/rep_sub_divider_if.sv
// Operand/result bus of the divider. The master drives start/data_in; the slave (divider) returns results.
interface rep_sub_divider_if
  import rep_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/rep_sub_divider_dp.sv
// Divider datapath: remainder, divisor and quotient registers with one subtractor
// and one comparator. The controller steers it with load/sub strobes.
module rep_sub_div_dp
  import rep_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a_i,   // dividend into remainder, clear quotient
  input  logic             load_b_i,   // capture divisor
  input  logic             sub_i,      // one subtract/increment step
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             ge_o,       // remainder >= divisor
  output logic             zero_o      // divisor == 0
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;

  // Next-state selection for the three registers; strobes are mutually exclusive.
  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    quo_d = quo_q;
    if (load_a_i) begin
      rem_d = data_i;
      quo_d = '0;
    end
    if (load_b_i) div_d = data_i;
    if (sub_i) begin
      rem_d = rem_q - div_q;
      quo_d = quo_q + WIDTH'(1);
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
    end
  end

  assign ge_o   = (rem_q >= div_q);
  assign zero_o = (div_q == '0);
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/rep_sub_divider.sv
// Unsigned divider by repeated subtraction. Dividend arrives with start, divisor
// one cycle later on the same bus. Takes Q+4 cycles (3 for divide-by-zero).
module rep_sub_divider
  import rep_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst,
  rep_sub_divider_if.slave   bus
);

  state_e state_q, state_d;
  logic   dz_q, dz_d;
  logic   ge, zero;
  logic   load_a, load_b, sub;

  // start is honoured only when idle or holding a result.
  assign load_a = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign load_b = (state_q == LOAD_B);
  assign sub    = (state_q == SUB) && ge;

  rep_sub_div_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_a_i (load_a),
    .load_b_i (load_b),
    .sub_i    (sub),
    .data_i   (bus.data_in),
    .quo_o    (bus.quotient),
    .rem_o    (bus.remainder),
    .ge_o     (ge),
    .zero_o   (zero)
  );

  // Controller next-state and divide-by-zero flag.
  always_comb begin
    state_d = state_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = LOAD_B;
        dz_d    = 1'b0;
      end
      LOAD_B: state_d = CHECK;
      CHECK: begin
        if (zero) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SUB;
        end
      end
      SUB: if (!ge) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and flag registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q == LOAD_B) || (state_q == CHECK) || (state_q == SUB);
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_rep_sub_divider.sv
// Bench for rep_sub_divider: directed table, reset/ignore-start sequence,
// long 65535/1 run and random vectors against an arithmetic model.
module tb_rep_sub_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rep_sub_divider_if #(.WIDTH(16)) bus ();

  rep_sub_divider #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Runs one division starting right now (#1 after an edge), returns in the
  // first done cycle. Random start pulses/garbage data are applied while busy.
  task automatic run_div(input vec_t v, input string tag);
    int n;
    bit busy_ok;
    bus.start   = 1'b1;
    bus.data_in = v.a;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.data_in = v.b;
    n = 1;
    chk({tag, " c1 done"}, bus.done, 0);
    chk({tag, " c1 busy"}, bus.busy, 1);
    busy_ok = 1'b1;
    while (!bus.done && n < 70000) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      bus.data_in = 16'($urandom);
      bus.start   = (v.lat < 100) ? 1'($urandom) : 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, " busy while running"}, busy_ok, 1);
    chk({tag, " latency"}, n, v.lat);
    chk({tag, " quotient"}, bus.quotient, v.q);
    chk({tag, " remainder"}, bus.remainder, v.r);
    chk({tag, " div_by_zero"}, bus.div_by_zero, v.dz);
    chk({tag, " busy in done"}, bus.busy, 0);
  endtask

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    v.a  = a;
    v.b  = b;
    v.dz = (b == 0);
    v.q  = v.dz ? 16'd0 : a / b;
    v.r  = v.dz ? a : a % b;
    v.lat = v.dz ? 3 : int'(v.q) + 4;
    return v;
  endfunction

  initial begin
    vec_t v;
    int k;
    logic [15:0] b, r, hq, hr;

    tbl[0] = '{16'd17,    16'd5,     16'd3,  16'd2,   1'b0, 7};
    tbl[1] = '{16'd20,    16'd4,     16'd5,  16'd0,   1'b0, 9};   // back-to-back from DONE
    tbl[2] = '{16'd5,     16'd7,     16'd0,  16'd5,   1'b0, 4};
    tbl[3] = '{16'd100,   16'd0,     16'd0,  16'd100, 1'b1, 3};
    tbl[4] = '{16'd9,     16'd3,     16'd3,  16'd0,   1'b0, 7};
    tbl[5] = '{16'd0,     16'd5,     16'd0,  16'd0,   1'b0, 4};
    tbl[6] = '{16'd0,     16'd0,     16'd0,  16'd0,   1'b1, 3};
    tbl[7] = '{16'd65535, 16'd65535, 16'd1,  16'd0,   1'b0, 5};
    tbl[8] = '{16'd1,     16'd1,     16'd1,  16'd0,   1'b0, 5};
    tbl[9] = '{16'd300,   16'd7,     16'd42, 16'd6,   1'b0, 46};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_in = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset done", bus.done, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset dz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle hold done", bus.done, 0);
    chk("idle hold busy", bus.busy, 0);

    // Directed table; entry 1 starts in the DONE cycle of entry 0.
    for (int i = 0; i < 10; i++) run_div(tbl[i], $sformatf("tbl%0d", i));

    // Result held in DONE while start stays low.
    hq = bus.quotient;
    hr = bus.remainder;
    repeat (3) @(posedge clk);
    #1;
    chk("hold done", bus.done, 1);
    chk("hold quotient", bus.quotient, 42);
    chk("hold remainder", bus.remainder, 6);

    // 1000/3 with ignored start at cycle 10 and reset at cycle 20.
    bus.start = 1'b1;
    bus.data_in = 16'd1000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.data_in = 16'd3;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      bus.start   = (n == 10);
      bus.data_in = (n == 10) ? 16'd7 : 16'($urandom);
      if (n == 11) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    // cycle 20: 17 subtractions of 3 have happened (first one ends cycle 3)
    chk("mid quotient", bus.quotient, 17);
    chk("mid remainder", bus.remainder, 1000 - 17 * 3);
    chk("mid busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst quotient", bus.quotient, 0);
    chk("rst remainder", bus.remainder, 0);
    chk("rst done", bus.done, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst dz", bus.div_by_zero, 0);
    @(posedge clk); #1;
    run_div(model(16'd9, 16'd3), "after rst 9/3");

    // Random vectors, mostly with small quotients to keep the run short.
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) begin
        v = model(16'($urandom), 16'd0);
      end else begin
        b = 16'($urandom_range(1, 65535));
        k = $urandom_range(0, 40);
        r = 16'($urandom_range(0, int'(b) - 1));
        if (longint'(k) * b + r <= 65535) v = model(16'(k * int'(b) + int'(r)), b);
        else v = model(r, b);
      end
      run_div(v, $sformatf("rnd%0d %0d/%0d", i, v.a, v.b));
    end

    // Longest case: 65535 / 1.
    run_div(tbl[0], "pre-long 17/5");
    run_div(model(16'd65535, 16'd1), "long 65535/1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
